// File: rtl/sha256_digest_reader.sv
// Captures a final SHA-256 digest, flags whether it meets the leading-zero difficulty,
// then streams H0..H7 out one 32-bit word per valid/ready handshake.
module sha256_digest_reader #(
  parameter int ZERO_BITS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         digest_valid,
  input  logic [255:0] digest_in,
  output logic         digest_ready,
  output logic         hit_valid,
  output logic         hit,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [31:0]  word_out,
  output logic [2:0]   word_idx,
  output logic         word_last,
  output logic         overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Ones over the top ZERO_BITS bits; the zero-width case needs its own branch.
  localparam logic [255:0] ZERO_MASK =
    (ZERO_BITS == 0) ? '0 : ({256{1'b1}} << (256 - ZERO_BITS));

  state_t       state_q, state_d;
  logic [255:0] digest_q, digest_d;
  logic         hit_q, hit_d;
  logic [2:0]   idx_q, idx_d;
  logic         overrun_q, overrun_d;
  logic         digest_hit;
  logic [31:0]  words [8];

  assign digest_hit = ((digest_in & ZERO_MASK) == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign words[gi] = digest_q[255-32*gi -: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      digest_q  <= '0;
      hit_q     <= 1'b0;
      idx_q     <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digest_q  <= digest_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    digest_d  = digest_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    // A digest offered while busy is dropped but remembered.
    overrun_d = overrun_q | (digest_valid && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (digest_valid) begin
          digest_d = digest_in;
          hit_d    = digest_hit;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        idx_d   = 3'd0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (word_ready) begin
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    digest_ready = (state_q == ST_IDLE);
    hit_valid    = (state_q == ST_CHECK);
    word_valid   = (state_q == ST_STREAM);
    word_out     = (state_q == ST_STREAM) ? words[idx_q] : 32'd0;
    word_last    = (state_q == ST_STREAM) && (idx_q == 3'd7);
    word_idx     = idx_q;
    hit          = hit_q;
    overrun      = overrun_q;
  end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Randomised bench for sha256_digest_reader: a transaction-level model (queue of expected
// words plus leading-zero count) is compared against the DUT every cycle.
module tb_sha256_digest_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         digest_valid = 1'b0;
  logic [255:0] digest_in = '0;
  logic         word_ready = 1'b1;
  logic         digest_ready, hit_valid, hit, word_valid, word_last, overrun;
  logic [31:0]  word_out;
  logic [2:0]   word_idx;

  // Extra instances only to observe hit at the difficulty extremes.
  logic         z0_rdy, z0_hv, z0_hit, z0_wv, z0_wl, z0_ovr;
  logic [31:0]  z0_wo;
  logic [2:0]   z0_wi;
  logic         zf_rdy, zf_hv, zf_hit, zf_wv, zf_wl, zf_ovr;
  logic [31:0]  zf_wo;
  logic [2:0]   zf_wi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha256_digest_reader #(.ZERO_BITS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest_in(digest_in),
    .digest_ready(digest_ready), .hit_valid(hit_valid), .hit(hit), .word_valid(word_valid),
    .word_ready(word_ready), .word_out(word_out), .word_idx(word_idx), .word_last(word_last),
    .overrun(overrun));

  sha256_digest_reader #(.ZERO_BITS(0)) u_z0 (
    .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest_in(digest_in),
    .digest_ready(z0_rdy), .hit_valid(z0_hv), .hit(z0_hit), .word_valid(z0_wv),
    .word_ready(word_ready), .word_out(z0_wo), .word_idx(z0_wi), .word_last(z0_wl),
    .overrun(z0_ovr));

  sha256_digest_reader #(.ZERO_BITS(256)) u_zf (
    .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest_in(digest_in),
    .digest_ready(zf_rdy), .hit_valid(zf_hv), .hit(zf_hit), .word_valid(zf_wv),
    .word_ready(word_ready), .word_out(zf_wo), .word_idx(zf_wi), .word_last(zf_wl),
    .overrun(zf_ovr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lead_zeros(input logic [255:0] d);
    int n = 0;
    for (int i = 255; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  // Reference model state
  logic [31:0] exp_q[$];
  bit          chk_pend = 0;
  bit          exp_hit = 0, exp_hit0 = 0, exp_hit256 = 0;
  bit          exp_ovr = 0;
  bit          mdl_on = 0;
  int          ready_mode = 0;
  int          pat_cnt = 0;

  always @(negedge clk) begin
    bit busy;
    if (mdl_on) begin
      chk("digest_ready", digest_ready, (!chk_pend && exp_q.size() == 0));
      chk("hit_valid", hit_valid, chk_pend);
      chk("word_valid", word_valid, (!chk_pend && exp_q.size() != 0));
      chk("overrun", overrun, exp_ovr);
      chk("hit", hit, exp_hit);
      chk("hit_zb0", z0_hit, exp_hit0);
      chk("hit_zb256", zf_hit, exp_hit256);
      if (!chk_pend && exp_q.size() != 0) begin
        chk("word_out", word_out, exp_q[0]);
        chk("word_idx", word_idx, 32'(8 - exp_q.size()));
        chk("word_last", word_last, exp_q.size() == 1);
      end else begin
        chk("word_idx_idle", word_idx, 0);
        chk("word_last_idle", word_last, 0);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      chk_pend   = 0;
      exp_hit    = 0;
      exp_hit0   = 0;
      exp_hit256 = 0;
      exp_ovr    = 0;
      mdl_on     = 1;
    end else if (mdl_on) begin
      busy = chk_pend || (exp_q.size() != 0);
      if (chk_pend) begin
        chk_pend = 0;
      end else if (exp_q.size() != 0 && word_ready) begin
        $display("word idx=%0d data=%08h last=%0d", 8 - exp_q.size(), exp_q[0], exp_q.size() == 1);
        void'(exp_q.pop_front());
      end
      if (digest_valid) begin
        if (busy) begin
          exp_ovr = 1;
          $display("digest %064h dropped (busy)", digest_in);
        end else begin
          for (int w = 0; w < 8; w++) exp_q.push_back(digest_in[255-32*w -: 32]);
          exp_hit    = (lead_zeros(digest_in) >= 32);
          exp_hit0   = 1;
          exp_hit256 = (lead_zeros(digest_in) >= 256);
          chk_pend   = 1;
          $display("digest %064h accepted lz=%0d hit=%0d", digest_in, lead_zeros(digest_in), exp_hit);
        end
      end
    end
  end

  // word_ready driver: 0 = tied high, 1 = pattern 1,0,0 repeating, 2 = random
  always @(posedge clk) begin
    #1;
    pat_cnt++;
    case (ready_mode)
      1:       word_ready = (pat_cnt % 3 == 0);
      2:       word_ready = ($urandom_range(0, 3) != 0);
      default: word_ready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] d);
    digest_valid = 1'b1;
    digest_in    = d;
    tick();
    digest_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!chk_pend && exp_q.size() == 0) done = 1;
      else tick();
    end
    if (!done) chk("idle_timeout", 0, 1);
    tick();
  endtask

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  logic [255:0] seq_d;
  logic [255:0] d;

  initial begin
    seq_d = 256'h00000000_11111111_22222222_33333333_44444444_55555555_66666666_77777777;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_word_out", word_out, 0);
    chk("rst_ready", digest_ready, 1);

    // Reference digest, ready high; check 10-cycle capture-to-idle
    send(seq_d);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9) chk("busy_window", digest_ready, 0);
      else       chk("idle_at_10", digest_ready, 1);
    end
    tick();

    // H0 = 1: one leading-zero bit short of 32
    d = seq_d;
    d[255:224] = 32'h00000001;
    send(d);
    wait_idle();

    // Stalling downstream
    ready_mode = 1;
    send(seq_d);
    wait_idle();
    ready_mode = 0;

    // Overrun during STREAM, then a fresh digest still accepted
    send(rand_digest());
    repeat (4) tick();
    send(rand_digest());
    wait_idle();
    send(seq_d);
    wait_idle();
    chk("overrun_sticky", overrun, 1);

    // Reset while word 4 is presented
    send(seq_d);
    for (int i = 0; i < 50; i++) begin
      if (!chk_pend && exp_q.size() == 4) break;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_valid", word_valid, 0);
    chk("rstmid_idx", word_idx, 0);
    chk("rstmid_ready", digest_ready, 1);
    chk("rstmid_ovr", overrun, 0);
    tick();

    // Difficulty boundaries
    send({256{1'b1}});
    wait_idle();
    send('0);
    wait_idle();
    d = 256'h1 << (255 - 31);
    send(d);
    wait_idle();
    d = 256'h1 << (255 - 32);
    send(d);
    wait_idle();
    d = 256'h1;
    send(d);
    wait_idle();

    // Random digests with random leading zeros, random ready, occasional overrun
    ready_mode = 2;
    for (int n = 0; n < 20; n++) begin
      d = rand_digest() >> $urandom_range(0, 48);
      send(d);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, 6)) tick();
        send(rand_digest());
      end
      wait_idle();
    end
    ready_mode = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
